// File: rtl/nco_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nco_meas_pkg
//  Purpose  : Shared types and constants for the NCO period meter.
//             Provides the measurement FSM state encoding, default widths
//             and the all-ones timeout value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package nco_meas_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } meas_state_t;

    // Default sample width (matches NCO magnitude precision)
    localparam int MPR_DEFAULT = 13;
    // Default period counter / result width
    localparam int CW_DEFAULT  = 24;
    // Width of the crossing (period) counter
    localparam int PER_W       = 8;

    // Result reported on timeout at the default counter width
    localparam logic [CW_DEFAULT-1:0] TIMEOUT_ALL_ONES = '1;

endpackage : nco_meas_pkg
`default_nettype wire

// File: rtl/nco_zc_detect.sv
`default_nettype none
// ============================================================================
//  Module   : nco_zc_detect
//  Purpose  : Rising zero-crossing detector with symmetric hysteresis.
//             A sample <= -HYS arms the detector; the next accepted sample
//             >= +HYS while armed is a crossing and disarms it.
//  Ports    : clk      - system clock
//             reset_n  - synchronous active-low reset
//             clken    - clock enable; arm flag only updates when high
//             clr      - clears the arm flag and suppresses crossings
//             sample   - signed input sample
//             accept   - sample qualifier (clken & valid)
//             crossing - combinational one-sample crossing pulse
//  Revision : 1.0 - initial release
// ============================================================================
module nco_zc_detect #(
    parameter int MPR = 13,
    parameter int HYS = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  clr,
    input  logic signed [MPR-1:0] sample,
    input  logic                  accept,
    output logic                  crossing
);

    localparam logic signed [MPR-1:0] HYS_POS = MPR'(HYS);
    localparam logic signed [MPR-1:0] HYS_NEG = -HYS_POS;

    logic arm;
    logic is_high;
    logic is_low;

    assign is_high  = (sample >= HYS_POS);
    assign is_low   = (sample <= HYS_NEG);
    // Samples inside the dead band leave arm untouched, so noise around
    // zero cannot produce a second crossing.
    assign crossing = accept & arm & is_high & ~clr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            arm <= 1'b0;
        end else if (clken) begin
            if (clr) begin
                arm <= 1'b0;
            end else if (accept) begin
                if (is_low) begin
                    arm <= 1'b1;
                end else if (is_high) begin
                    arm <= 1'b0;
                end
            end
        end
    end

endmodule : nco_zc_detect
`default_nettype wire

// File: rtl/nco_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : nco_period_meter
//  Purpose  : Measures the NCO output period by counting accepted samples
//             over NPER full periods between rising zero crossings.
//  Ports    : clk          - system clock
//             reset_n      - synchronous active-low reset
//             clken        - global clock enable shared with the NCO
//             fsin_i       - signed sine sample
//             valid_i      - sample valid
//             start_i      - measurement request (honoured in IDLE only)
//             busy_o       - measurement in progress
//             period_o     - samples counted over NPER periods (held)
//             meas_valid_o - one-cycle result strobe
//             timeout_o    - one-cycle timeout strobe
//  Revision : 1.0 - initial release
// ============================================================================
module nco_period_meter
    import nco_meas_pkg::*;
#(
    parameter int MPR  = MPR_DEFAULT,
    parameter int CW   = CW_DEFAULT,
    parameter int NPER = 16,
    parameter int HYS  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic signed [MPR-1:0] fsin_i,
    input  logic                  valid_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic [CW-1:0]         period_o,
    output logic                  meas_valid_o,
    output logic                  timeout_o
);

    localparam logic [CW-1:0]    CNT_MAX  = '1;
    // Accepting a sample while cnt holds this value makes cnt reach CNT_MAX
    localparam logic [CW-1:0]    CNT_LAST = CNT_MAX - CW'(1);
    localparam logic [PER_W-1:0] NPER_C   = PER_W'(NPER);

    meas_state_t      state;
    meas_state_t      state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [PER_W-1:0] per;
    logic [PER_W-1:0] per_nxt;
    logic [CW-1:0]    period_nxt;
    logic             timeout_nxt;
    logic             accept;
    logic             clr;
    logic             crossing;

    assign accept = clken & valid_i;

    nco_zc_detect #(
        .MPR (MPR),
        .HYS (HYS)
    ) u_zc_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .clken    (clken),
        .clr      (clr),
        .sample   (fsin_i),
        .accept   (accept),
        .crossing (crossing)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            per       <= '0;
            period_o  <= '0;
            timeout_o <= 1'b0;
        end else if (clken) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            per       <= per_nxt;
            period_o  <= period_nxt;
            timeout_o <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        per_nxt      = per;
        period_nxt   = period_o;
        timeout_nxt  = 1'b0;
        // Detector held disarmed while idle; this also discards the
        // sample presented in the start cycle.
        clr          = (state == IDLE);
        busy_o       = (state != IDLE);
        meas_valid_o = (state == DONE);

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = SYNC;
                    cnt_nxt   = '0;
                    per_nxt   = '0;
                end
            end
            SYNC: begin
                if (crossing) begin
                    state_nxt = MEAS;
                    cnt_nxt   = '0;
                    per_nxt   = '0;
                end else if (accept) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt     = CNT_MAX;
                        period_nxt  = CNT_MAX;
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            MEAS: begin
                if (accept) begin
                    // Completion wins over a coincident timeout; the
                    // crossing sample itself belongs to the measurement.
                    if (crossing && ((per + PER_W'(1)) == NPER_C)) begin
                        period_nxt = cnt + CW'(1);
                        state_nxt  = DONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt     = CNT_MAX;
                        period_nxt  = CNT_MAX;
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        if (crossing) begin
                            per_nxt = per + PER_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : nco_period_meter
`default_nettype wire
